dp_pipe_ctrl: RTL
=================

# dp_pipe_ctrl

Sequencer for the multi-precision multiplier/adder datapath pipeline (DP_pipe). It accepts operations from an upstream valid/ready source and tracks a valid bit, precision mode and tag per pipeline stage. It generates the per-stage register enables for the stage register banks and the pass-select for stage 1. DP operations need two passes through the shared multiplier array; the block sequences them with a small FSM and drives backpressure so that no stage register is overwritten while stalled.

## Interface
- STAGES, 4: number of pipeline register banks controlled (2..8).
- TAG_W, 4: width of the opaque op tag carried with each operation.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream op present.
- in_ready  output  1  controller accepts an op this cycle.
- in_mode  input  2  00 HP (4 lanes), 01 SP (2 lanes), 10 DP (1 lane, two passes), 11 reserved.
- in_tag  input  TAG_W  op tag.
- flush  input  1  synchronous kill of all in-flight ops.
- stage_en  output  STAGES  load enable for each stage register bank; bit 0 is the first bank.
- stage_valid  output  STAGES  valid bit per stage.
- pass_sel  output  1  stage-1 operand select: 0 = low/only pass, 1 = DP high pass.
- mode_s1  output  2  mode of the op currently loading stage 1, which drives the datapath lane configuration.
- out_valid  output  1  equals stage_valid[STAGES-1].
- out_ready  input  1  downstream accepts the result.
- out_mode  output  2  mode of the last stage.
- out_tag  output  TAG_W  tag of the last stage.
- err_rsv  output  1  one-cycle pulse when a reserved-mode op is accepted.

## Operation
- Stage advance rule: adv[STAGES-1] = out_ready | ~valid[STAGES-1]. For i < STAGES-1, adv[i] = ~valid[i] | adv[i+1].
- Bubbles collapse: a stage holds only while it is valid and the stage after it cannot take its content.
- stage_en[i] = adv[i]. On stage_en[i], stage i takes valid, mode and tag from stage i-1. Stage 0 takes them from the issue logic.
- FSM states:
  - IDLE: in_ready = adv[0]. On acceptance of HP or SP: issue with pass_sel = 0, stay in IDLE. On acceptance of DP: issue pass 0 with pass_sel = 0, latch the tag, go to DP_HI.
  - DP_HI: in_ready = 0. pass_sel = 1 while stage 0 loads the high pass. When adv[0] = 1, issue the high pass and return to IDLE. Otherwise hold in DP_HI.
- DP pass 0 enters stage 0 with valid = 0 and is held as an internal partial. Only the high pass carries valid = 1, mode 10 and the op tag. The result of one DP op is therefore one out_valid beat.
- Reserved mode 11: the op is accepted (in_ready handshake completes) but not issued. err_rsv pulses in the cycle after acceptance.
- flush:
  - Next cycle: all valid bits = 0, FSM = IDLE, in_ready = 0 for that flush cycle.
  - An in_valid & in_ready coincident with flush is discarded.
  - A flush that arrives mid-DP also discards pass 0.
- Simultaneous out_ready deassert and issue: issue proceeds only if the chain of adv reaches stage 0.

## Timing
- Reset values: stage_valid = 0, stage_en = all ones (banks clear/idle), in_ready = 1, pass_sel = 0, mode_s1 = 00, out_valid = 0, out_mode = 00, out_tag = 0, err_rsv = 0, FSM = IDLE.
- HP/SP latency, from the accept edge to out_valid: STAGES cycles with no stall. DP latency: STAGES+1 cycles.
- Throughput: HP/SP one op per cycle. DP one op per 2 cycles.
- All outputs are registered, except in_ready, stage_en and pass_sel, which are combinational from state, out_ready and valid bits.
- Reset asserted mid-operation clears everything asynchronously. No partial op survives.

## Configuration
- DP_PIPE_PERF_EN defined: adds 32-bit wrap-around counters, all cleared by rst and by flush, and exposed as extra outputs:
  - perf_issued: counts valid issues.
  - perf_stall: counts cycles with out_valid & ~out_ready.
  - perf_dp: counts DP ops completed.
- DP_PIPE_PERF_EN undefined: the counters and their ports are absent. All other behaviour is identical.

## Structure
- Shared package dp_pipe_pkg holds:
  - mode encodings MODE_HP/SP/DP/RSV;
  - FSM state constants IDLE/DP_HI;
  - default STAGES and TAG_W.
- Sub-module dp_stage_tag: one valid/mode/tag register slice with enable and flush, instantiated STAGES times.
- The FSM and issue logic live in the top level.

## Test plan
- Reset then 4 back-to-back HP ops, tags 1-4, with out_ready = 1 -> out_valid beats on cycles 4-7 with tags 1-4 and in_ready constantly 1.
- DP op, tag 5, then SP op, tag 6 -> in_ready = 0 for one cycle and pass_sel = 1 in that cycle. Tag 5 appears at cycle 5 with out_mode = 10; tag 6 appears at cycle 6.
- Fill the pipe, then hold out_ready = 0 for 3 cycles -> out_tag is stable, in_ready falls once all STAGES stages are valid, and no tag is lost or duplicated after release.
- Bubble collapse: issue op A, then wait 2 cycles, then issue op B while out_ready = 0 -> B advances until it sits directly behind A.
- flush asserted during DP_HI -> next cycle stage_valid = 0 and FSM = IDLE. No out_valid results for the flushed ops.
- in_mode = 11 -> handshake completes, err_rsv pulses one cycle, and no out_valid follows. With DP_PIPE_PERF_EN defined, perf_issued is unchanged.

Source files
------------

// File: rtl/dp_pipe_pkg.sv
// Shared definitions for the DP_pipe sequencer: mode encodings, FSM states
// and default geometry.
package dp_pipe_pkg;

  localparam int STAGES_DEF = 4;
  localparam int TAG_W_DEF  = 4;

  localparam logic [1:0] MODE_HP  = 2'b00;
  localparam logic [1:0] MODE_SP  = 2'b01;
  localparam logic [1:0] MODE_DP  = 2'b10;
  localparam logic [1:0] MODE_RSV = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    DP_HI = 1'b1
  } state_t;

  // HP and SP ops need a single trip through the multiplier array.
  function automatic logic is_single_pass(input logic [1:0] mode);
    return (mode == MODE_HP) || (mode == MODE_SP);
  endfunction

endpackage

// File: rtl/dp_pipe_ctrl_if.sv
// Upstream op handshake, downstream result handshake and datapath controls
// of the DP_pipe sequencer. master = op source / result sink side,
// slave = the sequencer itself.
interface dp_pipe_ctrl_if
  import dp_pipe_pkg::*;
#(
  parameter int STAGES = STAGES_DEF,
  parameter int TAG_W  = TAG_W_DEF
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_mode;
  logic [TAG_W-1:0]  in_tag;
  logic              flush;
  logic [STAGES-1:0] stage_en;
  logic [STAGES-1:0] stage_valid;
  logic              pass_sel;
  logic [1:0]        mode_s1;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        out_mode;
  logic [TAG_W-1:0]  out_tag;
  logic              err_rsv;

  modport master (
    output in_valid, in_mode, in_tag, flush, out_ready,
    input  in_ready, stage_en, stage_valid, pass_sel, mode_s1,
           out_valid, out_mode, out_tag, err_rsv
  );

  modport slave (
    input  in_valid, in_mode, in_tag, flush, out_ready,
    output in_ready, stage_en, stage_valid, pass_sel, mode_s1,
           out_valid, out_mode, out_tag, err_rsv
  );
endinterface

// File: rtl/dp_pipe_ctrl_stage_tag.sv
// One pipeline stage of control state: valid bit, precision mode and tag.
// Flush kills the valid bit only; mode and tag are left as they were.
module dp_stage_tag
  import dp_pipe_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic             valid_d,
  input  logic [1:0]       mode_d,
  input  logic [TAG_W-1:0] tag_d,
  output logic             valid_q,
  output logic [1:0]       mode_q,
  output logic [TAG_W-1:0] tag_q
);

  // Stage slice register: flush wins over load.
  // NOTE: sequential state uses non-blocking assignments so every slice
  // samples its predecessor's pre-edge value, giving a true shift chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      mode_q  <= MODE_HP;
      tag_q   <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (en) begin
      valid_q <= valid_d;
      mode_q  <= mode_d;
      tag_q   <= tag_d;
    end
  end

endmodule

// File: rtl/dp_pipe_ctrl.sv
// DP_pipe sequencer: per-stage valid/mode/tag tracking, stage enables with
// bubble collapse, and the two-pass DP issue FSM.
// Optional feature macro: DP_PIPE_PERF_EN adds perf_issued, perf_stall and
// perf_dp counters (32-bit, wrap-around, cleared by rst and flush).
module dp_pipe_ctrl
  import dp_pipe_pkg::*;
#(
  parameter int STAGES = STAGES_DEF,
  parameter int TAG_W  = TAG_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  dp_pipe_ctrl_if.slave bus
`ifdef DP_PIPE_PERF_EN
  ,
  output logic [31:0] perf_issued,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_dp
`endif
);

  state_t            state_q, state_d;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;
  logic [1:0]        mode_q [STAGES];
  logic [1:0]        mode_d [STAGES];
  logic [TAG_W-1:0]  tag_q  [STAGES];
  logic [TAG_W-1:0]  tag_d  [STAGES];
  logic              in_ready;
  logic              accept;
  logic              issue_valid;
  logic [1:0]        issue_mode;
  logic [TAG_W-1:0]  issue_tag;
  logic [TAG_W-1:0]  dp_tag_q;
  logic              err_q;

  // Advance chain: a stage may load when it is empty or everything ahead moves.
  always_comb begin
    logic chain;
    adv   = '0;
    chain = bus.out_ready | ~valid_q[STAGES-1];
    adv[STAGES-1] = chain;
    for (int i = STAGES - 2; i >= 0; i--) begin
      chain  = ~valid_q[i] | chain;
      adv[i] = chain;
    end
  end

  // Issue FSM next state and stage-0 load contents.
  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    in_ready    = 1'b0;
    accept      = 1'b0;
    issue_valid = 1'b0;
    issue_mode  = MODE_HP;
    issue_tag   = '0;
    case (state_q)
      IDLE: begin
        in_ready = adv[0] & ~bus.flush;
        accept   = bus.in_valid & in_ready;
        if (accept) begin
          if (is_single_pass(bus.in_mode)) begin
            issue_valid = 1'b1;
            issue_mode  = bus.in_mode;
            issue_tag   = bus.in_tag;
          end else if (bus.in_mode == MODE_DP) begin
            // Pass 0 is an internal partial: it loads stage 0 without valid.
            issue_mode = MODE_DP;
            issue_tag  = bus.in_tag;
            state_d    = DP_HI;
          end
        end
      end
      DP_HI: begin
        if (adv[0]) begin
          issue_valid = 1'b1;
          issue_mode  = MODE_DP;
          issue_tag   = dp_tag_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (bus.flush) state_d = IDLE;
  end

  // FSM state register.
  // NOTE: reset is asynchronous active-low so a mid-operation reset clears
  // every stage immediately, independent of the clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Hold the DP tag for the high pass.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                    dp_tag_q <= '0;
    else if (accept && bus.in_mode == MODE_DP)   dp_tag_q <= bus.in_tag;
  end

  // Reserved-mode ops are swallowed; flag them one cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= accept && (bus.in_mode == MODE_RSV);
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    if (g == 0) begin : g_first
      assign valid_d[g] = issue_valid;
      assign mode_d[g]  = issue_mode;
      assign tag_d[g]   = issue_tag;
    end else begin : g_rest
      assign valid_d[g] = valid_q[g-1];
      assign mode_d[g]  = mode_q[g-1];
      assign tag_d[g]   = tag_q[g-1];
    end

    dp_stage_tag #(.TAG_W(TAG_W)) u_stage (
      .clk     (clk),
      .rst     (rst),
      .en      (adv[g]),
      .flush   (bus.flush),
      .valid_d (valid_d[g]),
      .mode_d  (mode_d[g]),
      .tag_d   (tag_d[g]),
      .valid_q (valid_q[g]),
      .mode_q  (mode_q[g]),
      .tag_q   (tag_q[g])
    );
  end

  assign bus.in_ready    = in_ready;
  assign bus.stage_en    = adv;
  assign bus.stage_valid = valid_q;
  assign bus.pass_sel    = (state_q == DP_HI);
  assign bus.mode_s1     = mode_q[0];
  assign bus.out_valid   = valid_q[STAGES-1];
  assign bus.out_mode    = mode_q[STAGES-1];
  assign bus.out_tag     = tag_q[STAGES-1];
  assign bus.err_rsv     = err_q;

`ifdef DP_PIPE_PERF_EN
  // Performance counters: issues, output stalls, completed DP ops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_issued <= '0;
      perf_stall  <= '0;
      perf_dp     <= '0;
    end else if (bus.flush) begin
      perf_issued <= '0;
      perf_stall  <= '0;
      perf_dp     <= '0;
    end else begin
      if (issue_valid)
        perf_issued <= perf_issued + 32'd1;
      if (valid_q[STAGES-1] && !bus.out_ready)
        perf_stall <= perf_stall + 32'd1;
      if (valid_q[STAGES-1] && bus.out_ready && mode_q[STAGES-1] == MODE_DP)
        perf_dp <= perf_dp + 32'd1;
    end
  end
`endif

endmodule
